// File: rtl/dcache_pkg.sv
// Shared geometry, FSM states and address/line helpers for the direct-mapped
// write-back data cache.
package dcache_pkg;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_NUM_LINES = 32;
  localparam int DEF_LINE_W    = 256;

  localparam int OFF_W = 3;
  localparam int IDX_W = $clog2(DEF_NUM_LINES);
  localparam int TAG_W = DEF_ADDR_W - 5 - IDX_W;

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, REFILL} state_e;

  function automatic logic [TAG_W-1:0] get_tag(input logic [DEF_ADDR_W-1:0] addr);
    return addr[DEF_ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] get_idx(input logic [DEF_ADDR_W-1:0] addr);
    return addr[5 +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] get_off(input logic [DEF_ADDR_W-1:0] addr);
    return addr[2 +: OFF_W];
  endfunction

  function automatic logic [31:0] get_word(input logic [DEF_LINE_W-1:0] line,
                                           input logic [OFF_W-1:0] off);
    return line[off*32 +: 32];
  endfunction

  function automatic logic [DEF_LINE_W-1:0] put_word(input logic [DEF_LINE_W-1:0] line,
                                                     input logic [OFF_W-1:0] off,
                                                     input logic [31:0] word);
    logic [DEF_LINE_W-1:0] l;
    l = line;
    l[off*32 +: 32] = word;
    return l;
  endfunction
endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: one combinational read port and one
// synchronous write port sharing the access index.
module dcache_sram #(
  parameter int NUM_LINES = 32,
  parameter int TAG_W     = 22,
  parameter int LINE_W    = 256,
  localparam int IDX_W    = $clog2(NUM_LINES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  i_idx,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [LINE_W-1:0] o_line,
  input  logic              i_we,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [LINE_W-1:0] i_line,
  input  logic              i_valid,
  input  logic              i_dirty
);
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_we) begin
      r_valid[i_idx] <= i_valid;
      r_dirty[i_idx] <= i_dirty;
    end
  end

  // Contents survive reset; a cleared valid bit makes them unreachable.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_tag[i_idx]  <= i_tag;
      r_data[i_idx] <= i_line;
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller: hit logic,
// word merge, stall generation and the write-back/refill FSM.
module dcache_controller #(
  parameter int NUM_LINES = dcache_pkg::DEF_NUM_LINES,
  parameter int LINE_W    = dcache_pkg::DEF_LINE_W,
  parameter int ADDR_W    = dcache_pkg::DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p1_req_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  import dcache_pkg::*;

  state_e r_state, w_nxt;
  logic [TAG_W-1:0]  w_tag, w_line_tag, w_wr_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_off;
  logic              w_valid, w_dirty, w_hit, w_load_hit;
  logic [LINE_W-1:0] w_line, w_wr_line;
  logic              w_we, w_wr_valid, w_wr_dirty;
  logic [31:0]       w_word, r_p1_data;
  logic              r_mem_en, r_mem_wr, w_mem_en, w_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [LINE_W-1:0] r_mem_data, w_mem_data;

  assign w_tag = get_tag(p1_addr_i);
  assign w_idx = get_idx(p1_addr_i);
  assign w_off = get_off(p1_addr_i);

  dcache_sram #(.NUM_LINES(NUM_LINES), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_idx   (w_idx),
    .o_valid (w_valid),
    .o_dirty (w_dirty),
    .o_tag   (w_line_tag),
    .o_line  (w_line),
    .i_we    (w_we & ~rst_i),
    .i_tag   (w_wr_tag),
    .i_line  (w_wr_line),
    .i_valid (w_wr_valid),
    .i_dirty (w_wr_dirty)
  );

  assign w_hit      = p1_req_i & w_valid & (w_line_tag == w_tag);
  assign w_word     = get_word(w_line, w_off);
  assign w_load_hit = (r_state == IDLE) & w_hit & ~p1_write_i;
  assign p1_stall_o = (r_state != IDLE) | (p1_req_i & ~w_hit);
  assign p1_data_o  = w_load_hit ? w_word : r_p1_data;

  assign mem_enable_o = r_mem_en;
  assign mem_write_o  = r_mem_wr;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;

  always_comb begin
    w_nxt      = r_state;
    w_we       = 1'b0;
    w_wr_tag   = w_line_tag;
    w_wr_line  = w_line;
    w_wr_valid = w_valid;
    w_wr_dirty = w_dirty;
    w_mem_en   = r_mem_en;
    w_mem_wr   = r_mem_wr;
    w_mem_addr = r_mem_addr;
    w_mem_data = r_mem_data;
    case (r_state)
      IDLE: begin
        if (w_hit && p1_write_i) begin
          w_we       = 1'b1;
          w_wr_line  = put_word(w_line, w_off, p1_data_i);
          w_wr_dirty = 1'b1;
        end else if (p1_req_i && !w_hit) begin
          // Request outputs are registered here so they are live in *_REQ.
          w_mem_en = 1'b1;
          if (w_valid && w_dirty) begin
            w_nxt      = WB_REQ;
            w_mem_wr   = 1'b1;
            w_mem_addr = {w_line_tag, w_idx, 5'b0};
            w_mem_data = w_line;
          end else begin
            w_nxt      = RD_REQ;
            w_mem_wr   = 1'b0;
            w_mem_addr = {w_tag, w_idx, 5'b0};
          end
        end
      end
      WB_REQ:  w_nxt = WB_WAIT;
      WB_WAIT: begin
        if (mem_ack_i) begin
          w_we       = 1'b1;
          w_wr_dirty = 1'b0;
          w_nxt      = RD_REQ;
          w_mem_wr   = 1'b0;
          w_mem_addr = {w_tag, w_idx, 5'b0};
        end
      end
      RD_REQ:  w_nxt = RD_WAIT;
      RD_WAIT: begin
        if (mem_ack_i) begin
          w_we       = 1'b1;
          w_wr_line  = mem_data_i;
          w_wr_tag   = w_tag;
          w_wr_valid = 1'b1;
          w_wr_dirty = 1'b0;
          w_mem_en   = 1'b0;
          w_nxt      = REFILL;
        end
      end
      REFILL:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_mem_en   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_p1_data  <= '0;
    end else begin
      r_state    <= w_nxt;
      r_mem_en   <= w_mem_en;
      r_mem_wr   <= w_mem_wr;
      r_mem_addr <= w_mem_addr;
      r_mem_data <= w_mem_data;
      if (w_load_hit) r_p1_data <= w_word;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: abstract cache/memory model, a
// variable-latency memory responder and a per-cycle compare process.
module tb_dcache_controller;
  logic         clk = 1'b0;
  logic         rst;
  logic         p1_req, p1_write;
  logic [31:0]  p1_addr, p1_wdata, p1_rdata;
  logic         stall;
  logic         mem_en, mem_wr, mem_ack;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst),
    .p1_req_i(p1_req), .p1_write_i(p1_write), .p1_addr_i(p1_addr),
    .p1_data_i(p1_wdata), .p1_data_o(p1_rdata), .p1_stall_o(stall),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing memory: untouched lines read as a known address pattern.
  logic [255:0] bmem [logic [31:0]];
  logic [255:0] gmem [logic [31:0]];

  function automatic logic [255:0] pattern(input logic [31:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'h1000_0000 | (la + 32'(4*k));
    return l;
  endfunction
  function automatic logic [255:0] b_rd(input logic [31:0] la);
    return bmem.exists(la) ? bmem[la] : pattern(la);
  endfunction
  function automatic logic [255:0] g_rd(input logic [31:0] la);
    return gmem.exists(la) ? gmem[la] : pattern(la);
  endfunction

  typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } txn_t;
  txn_t txq[$];

  int   lat_rd = 1, lat_wb = 1, cnt, cur_lat;
  bit   busy = 0, cur_wr;
  logic [31:0] cur_addr;
  logic r_ack = 1'b0, spur_ack = 1'b0;
  assign mem_ack = r_ack | spur_ack;

  always @(posedge clk) begin
    #1;
    if (r_ack) begin r_ack = 1'b0; busy = 0; end
    if (busy && !mem_en) busy = 0;   // abandoned by reset
    if (busy) begin
      cnt++;
      if (cnt == cur_lat) begin
        r_ack = 1'b1;
        if (!cur_wr) mem_rdata = b_rd(cur_addr);
      end
    end else if (mem_en === 1'b1) begin
      busy = 1; cnt = 0; cur_wr = mem_wr; cur_addr = mem_addr;
      cur_lat = mem_wr ? lat_wb : lat_rd;
      txq.push_back('{mem_wr, mem_addr, mem_wr ? mem_wdata : '0});
      if (mem_wr) bmem[mem_addr] = mem_wdata;
    end
  end

  // Abstract cache model
  bit          mvalid [32];
  bit          mdirty [32];
  logic [21:0] mtag   [32];
  logic [255:0] mline [32];

  // Per-cycle compare process
  bit   chk_en = 0, acc_done = 0, exp_load = 0;
  int   exp_n, cyc, stall_cnt;
  logic [31:0] exp_word;

  always @(negedge clk) begin
    if (chk_en && !acc_done) begin
      chk("stall", stall, 256'(cyc < exp_n));
      stall_cnt += int'(stall);
      if (cyc >= exp_n) begin
        if (exp_load) chk("load data", p1_rdata, exp_word);
        acc_done = 1;
      end
      cyc++;
    end
  end

  // CPU must hold p1_* stable while stalled
  bit          ps = 0;
  logic [65:0] pv;
  always @(negedge clk) begin
    if (ps && !rst) chk("p1 held during stall", {p1_req, p1_write, p1_addr, p1_wdata}, pv);
    ps = stall;
    pv = {p1_req, p1_write, p1_addr, p1_wdata};
  end

  // Called right after a posedge; returns right after the posedge that completes the access.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int lwb, input int lrd, input int lit_stall);
    logic [4:0]  ix;
    logic [21:0] tg;
    logic [31:0] va;
    txn_t        eq[$];
    int          n;
    ix = a[9:5]; tg = a[31:10]; n = 0;
    if (!(mvalid[ix] && mtag[ix] == tg)) begin
      n = 3 + lrd;
      if (mvalid[ix] && mdirty[ix]) begin
        n += 1 + lwb;
        va = {mtag[ix], ix, 5'b0};
        eq.push_back('{1'b1, va, mline[ix]});
        gmem[va] = mline[ix];
      end
      eq.push_back('{1'b0, {tg, ix, 5'b0}, '0});
      mline[ix] = g_rd({tg, ix, 5'b0});
      mtag[ix] = tg; mvalid[ix] = 1; mdirty[ix] = 0;
    end
    if (wr) begin
      mline[ix][a[4:2]*32 +: 32] = d;
      mdirty[ix] = 1;
    end
    exp_word = mline[ix][a[4:2]*32 +: 32];
    lat_wb = lwb; lat_rd = lrd;
    txq.delete();
    #2;
    p1_req = 1'b1; p1_write = wr; p1_addr = a; p1_wdata = d;
    exp_n = n; exp_load = !wr; cyc = 0; stall_cnt = 0; acc_done = 0; chk_en = 1;
    for (int i = 0; i < 300 && !acc_done; i++) @(posedge clk);
    if (!acc_done) chk("access timeout", 0, 1);
    chk_en = 0;
    chk("txn count", txq.size(), eq.size());
    foreach (eq[i]) if (i < txq.size()) begin
      chk("txn kind", txq[i].wr, eq[i].wr);
      chk("txn addr", txq[i].addr, eq[i].addr);
      if (eq[i].wr) chk("txn wb data", txq[i].data, eq[i].data);
    end
    if (lit_stall >= 0) chk("stall cycles", stall_cnt, lit_stall);
  endtask

  task automatic chk_wb_word(input int k, input logic [31:0] exp_addr, input logic [31:0] w);
    if (txq.size() == 0) chk("wb present", 0, 1);
    else begin
      chk("wb addr literal", txq[0].addr, exp_addr);
      chk("wb word literal", txq[0].data[k*32 +: 32], w);
    end
  endtask

  initial begin
    logic [255:0] l40;
    rst = 1'b1; p1_req = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_wdata = '0;
    mem_rdata = '0;
    l40 = pattern(32'h40);
    l40[31:0] = 32'hDEAD_BEEF;
    bmem[32'h40] = l40; gmem[32'h40] = l40;
    for (int i = 0; i < 32; i++) begin mvalid[i] = 0; mdirty[i] = 0; end

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset stall", stall, 0);
    chk("reset mem_enable", mem_en, 0);
    chk("reset mem_write", mem_wr, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_data", mem_wdata, 0);
    chk("reset p1_data", p1_rdata, 0);
    @(posedge clk);

    access(0, 32'h40, 0, 1, 3, 6);
    chk("cold load literal", p1_rdata, 32'hDEAD_BEEF);
    access(1, 32'h44, 32'h1234_5678, 1, 1, 0);
    access(0, 32'h44, 0, 1, 1, 0);
    chk("store-then-load literal", p1_rdata, 32'h1234_5678);
    access(0, 32'h440, 0, 2, 1, 7);
    chk_wb_word(1, 32'h40, 32'h1234_5678);
    access(1, 32'h84, 32'hCAFE_F00D, 1, 2, 5);
    access(0, 32'h484, 0, 1, 1, 6);
    chk_wb_word(1, 32'h80, 32'hCAFE_F00D);

    // Reset while waiting for a refill
    txq.delete(); lat_rd = 50;
    #2 p1_req = 1'b1; p1_write = 1'b0; p1_addr = 32'h1000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("enable in RD_WAIT", mem_en, 1);
    chk("stall in RD_WAIT", stall, 1);
    @(posedge clk);
    #2 rst = 1'b1; p1_req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("enable after reset", mem_en, 0);
    chk("stall after reset", stall, 0);
    chk("abandoned read count", txq.size(), 1);
    for (int i = 0; i < 32; i++) begin mvalid[i] = 0; mdirty[i] = 0; end
    @(posedge clk);
    access(0, 32'h1000, 0, 1, 1, 4);

    // Spurious ack in IDLE, then eight back-to-back hits
    #2 p1_req = 1'b0; spur_ack = 1'b1;
    @(posedge clk);
    #2 spur_ack = 1'b0;
    @(negedge clk);
    chk("spurious ack stall", stall, 0);
    chk("spurious ack enable", mem_en, 0);
    @(posedge clk);
    for (int k = 0; k < 8; k++) access(0, 32'h1000 + 32'(4*k), 0, 1, 1, 0);
    #2 p1_req = 1'b0;
    @(negedge clk);
    chk("p1_data holds", p1_rdata, 32'h1000_101C);
    chk("idle no stall", stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
